display_sched: RTL and testbench

//  Time-shares the 4-digit 7-segment display (display0..display3) between NSRC value sources.

---
 rtl/display_pkg.sv | 35 +++
 rtl/bin2bcd_seq.sv | 46 ++++
 rtl/display_sched.sv | 131 +++++++++++++
 tb/tb_display_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and 7-segment codes for the display scheduler.
// Segment bit order is {g,f,e,d,c,b,a}, active low.
package display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD, SHOW} state_e;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1011000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per cycle, W cycles per value.
// done is high during the cycle whose edge performs the final shift.
module bin2bcd_seq #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         done,
  output logic [15:0]  bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  bin_q;
  logic [15:0]   bcd_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(W);
    end else if (cnt_q != '0) begin
      bcd_q <= {adj[14:0], bin_q[W-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/display_sched.sv
// Round-robin time-sharing of a 4-digit 7-segment display between NSRC sources:
// grant, sequential BCD conversion, registered decode, then hold for DWELL cycles.
module display_sched
  import display_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int W     = 10,
  parameter int DWELL = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC*W-1:0] val,
  output logic [NSRC-1:0]   grant,
  output logic              busy,
  output logic [2:0]        cur_src,
  output logic [6:0]        display0,
  output logic [6:0]        display1,
  output logic [6:0]        display2,
  output logic [6:0]        display3
);

  localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [CW-1:0] DW_LAST = CW'((DWELL > 0) ? DWELL - 1 : 0);

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d, cur_q, cur_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic [CW-1:0]   dw_q, dw_d;
  logic [3:0][6:0] disp_q, disp_d;

  logic [7:0]      req_ext;
  logic [3:0]      idx;
  logic [2:0]      sel;
  logic            found;
  logic [W-1:0]    sel_val;
  logic            start, done;
  logic [15:0]     bcd;

  // First requester at or after ptr; walking downward lets the nearest one win.
  always_comb begin
    req_ext = '0;
    req_ext[NSRC-1:0] = req;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = 4'(ptr_q) + 4'(i);
      if (idx >= 4'(NSRC)) idx = idx - 4'(NSRC);
      if (req_ext[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NSRC; i++)
      if (sel == 3'(i)) sel_val = val[i*W +: W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    grant_d = '0;
    dw_d    = dw_q;
    disp_d  = disp_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        start = 1'b1;
        for (int i = 0; i < NSRC; i++) grant_d[i] = (sel == 3'(i));
        cur_d   = sel;
        ptr_d   = (sel == 3'(NSRC - 1)) ? 3'd0 : sel + 3'd1;
        state_d = CONV;
      end
      CONV: if (done) state_d = LOAD;
      LOAD: begin
        for (int d = 0; d < 4; d++) disp_d[d] = seg7(bcd[d*4 +: 4]);
        state_d = (DWELL == 0) ? IDLE : SHOW;
      end
      SHOW: begin
        if (dw_q == DW_LAST) begin
          dw_d    = '0;
          state_d = IDLE;
        end else begin
          dw_d = dw_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      grant_q <= '0;
      dw_q    <= '0;
      disp_q  <= {4{SEG_DASH}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      grant_q <= grant_d;
      dw_q    <= dw_d;
      disp_q  <= disp_d;
    end
  end

  bin2bcd_seq #(.W(W)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (sel_val),
    .done  (done),
    .bcd   (bcd)
  );

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign cur_src  = cur_q;
  assign display0 = disp_q[0];
  assign display1 = disp_q[1];
  assign display2 = disp_q[2];
  assign display3 = disp_q[3];

endmodule

// File: tb/tb_display_sched.sv
// Randomised and directed checks of display_sched against a transaction-level model:
// a grant reserves the display for W+1+DWELL cycles and shows the decimal digits W+1 edges later.
module tb_display_sched;

  localparam int NSRC  = 3;
  localparam int W     = 10;
  localparam int DWELL = 4;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                                       7'b0000000, 7'b0010000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NSRC-1:0]   req = '0;
  logic [NSRC*W-1:0] val = '0;
  logic [NSRC-1:0]   grant;
  logic              busy;
  logic [2:0]        cur_src;
  logic [6:0]        display0, display1, display2, display3;

  int n_cmp = 0;
  int n_err = 0;

  display_sched #(.NSRC(NSRC), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val(val), .grant(grant), .busy(busy),
    .cur_src(cur_src), .display0(display0), .display1(display1),
    .display2(display2), .display3(display3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: countdowns in cycles, digits by plain decimal arithmetic.
  int              t_rem, t_show, m_ptr, m_cur, pick, v;
  logic [NSRC-1:0] m_grant;
  logic [6:0]      m_disp [4];
  logic [6:0]      m_pend [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_rem = 0; t_show = 0; m_ptr = 0; m_cur = 0; m_grant = '0;
      for (int d = 0; d < 4; d++) m_disp[d] = DASH;
    end else begin
      m_grant = '0;
      if (t_show > 0) begin
        t_show--;
        if (t_show == 0) m_disp = m_pend;
      end
      if (t_rem > 0) t_rem--;
      else if (req != '0) begin
        pick = -1;
        for (int i = 0; i < NSRC; i++)
          if (pick < 0 && req[(m_ptr + i) % NSRC]) pick = (m_ptr + i) % NSRC;
        m_grant[pick] = 1'b1;
        m_cur  = pick;
        m_ptr  = (pick + 1) % NSRC;
        v      = int'(val[pick*W +: W]);
        m_pend[0] = SEGS[v % 10];
        m_pend[1] = SEGS[(v / 10) % 10];
        m_pend[2] = SEGS[(v / 100) % 10];
        m_pend[3] = SEGS[(v / 1000) % 10];
        t_show = W + 1;
        t_rem  = W + 1 + DWELL;
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(t_rem > 0));
    chk("cur_src", 32'(cur_src), 32'(m_cur));
    chk("displays", 32'({display3, display2, display1, display0}),
        32'({m_disp[3], m_disp[2], m_disp[1], m_disp[0]}));
  end

  function automatic logic [31:0] shown();
    return 32'({display3, display2, display1, display0});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_val(input int s, input int x);
    val[s*W +: W] = W'(x);
  endtask

  initial begin
    // reset and quiet idle
    tick(3);
    chk("rst_disp", shown(), 32'({DASH, DASH, DASH, DASH}));
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick(100);
    chk("idle_disp", shown(), 32'({DASH, DASH, DASH, DASH}));
    chk("idle_busy", 32'(busy), 32'd0);

    // single source 1023
    req = 3'b001; set_val(0, 1023);
    tick(1);
    chk("t2_grant", 32'(grant), 32'b001);
    req = '0;
    tick(W + 1);
    chk("t2_1023", shown(), 32'({7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000}));
    tick(DWELL - 1);
    chk("t2_busy_hold", 32'(busy), 32'd1);
    tick(1);
    chk("t2_busy_fall", 32'(busy), 32'd0);

    // round robin between two held requests (pointer now at source 1)
    req = 3'b011; set_val(0, 5); set_val(1, 987);
    tick(1);
    chk("t3_grant_a", 32'(grant), 32'b010);
    tick(W + 1);
    chk("t3_0987", shown(), 32'({7'b1000000, 7'b0010000, 7'b0000000, 7'b1011000}));
    tick(DWELL + 1);
    chk("t3_grant_b", 32'(grant), 32'b001);
    tick(W + 1);
    chk("t3_0005", shown(), 32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}));
    tick(DWELL + 1);
    chk("t3_grant_c", 32'(grant), 32'b010);
    req = '0;
    tick(W + 1 + DWELL);

    // value captured on the grant edge only
    req = 3'b001; set_val(0, 42);
    tick(1);
    set_val(0, 7); req = '0;
    tick(W + 1);
    chk("t4_0042", shown(), 32'({7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}));
    tick(DWELL);

    // reset in the middle of a conversion
    req = 3'b001; set_val(0, 999);
    tick(1);
    req = '0;
    tick(3);
    #2 rst_n = 1'b0;
    tick(1);
    chk("t5_rst_disp", shown(), 32'({DASH, DASH, DASH, DASH}));
    chk("t5_rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    tick(1);
    req = 3'b001; set_val(0, 0);
    tick(1);
    req = '0;
    tick(W + 1);
    chk("t5_0000", shown(), 32'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
    tick(DWELL);

    // every 10-bit value through source 0
    for (int x = 0; x < 1024; x++) begin
      req = 3'b001; set_val(0, x);
      tick(1);
      req = '0;
      tick(W + 1 + DWELL);
    end

    // random contention
    for (int c = 0; c < 3000; c++) begin
      req = NSRC'($urandom_range(0, (1 << NSRC) - 1));
      for (int s = 0; s < NSRC; s++)
        if ($urandom_range(0, 3) == 0) set_val(s, int'($urandom_range(0, 1023)));
      tick(1);
    end
    req = '0;
    tick(W + DWELL + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
